// File: rtl/count1to10_monitor.sv
// Sequence monitor for a 1..10 decade counter: locks after LOCK_LEN in-sequence samples, then flags every break (lap counter with COUNT1TO10_MON_LAP_EN).
// Latency: all outputs registered; the response to a q_valid sample is visible one cycle later.
// Backpressure: none; q_valid low holds all state, while err_pulse drops and err_clr still acts.
module count1to10_monitor #(
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned LAP_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q,
    input  logic             q_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
`ifdef COUNT1TO10_MON_LAP_EN
    ,
    output logic [LAP_W-1:0] lap_count
`endif
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    if (LOCK_LEN < 2 || LOCK_LEN > 15) begin : g_bad_lock_len
        $error("LOCK_LEN must be in 2..15");
    end
    if (ERR_W < 1 || LAP_W < 1) begin : g_bad_width
        $error("ERR_W and LAP_W must be at least 1");
    end

    function automatic logic [3:0] succ(input logic [3:0] x);
        return (x == 4'd10) ? 4'd1 : x + 4'd1;
    endfunction

    state_t           state;
    logic [3:0]       prev;
    logic             prev_ok;
    logic [3:0]       run;

    logic             q_in_range;
    logic [3:0]       run_nxt;
    logic             seq_match;
    logic [ERR_W-1:0] err_count_inc;

    assign q_in_range    = (q >= 4'd1) && (q <= 4'd10);
    assign run_nxt       = (prev_ok && (q == succ(prev))) ? run + 4'd1 : 4'd1;
    assign seq_match     = (q == expected);
    assign err_count_inc = (&err_count) ? err_count : err_count + ERR_ONE;
    assign locked        = (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            prev       <= 4'd0;
            prev_ok    <= 1'b0;
            run        <= 4'd0;
            expected   <= 4'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end
            if (q_valid) begin
                case (state)
                    SEARCH: begin
                        if (!q_in_range) begin
                            run     <= 4'd0;
                            prev_ok <= 1'b0;
                        end else begin
                            run     <= run_nxt;
                            prev    <= q;
                            prev_ok <= 1'b1;
                            if (run_nxt == LOCK_RUN) begin
                                state    <= LOCKED;
                                expected <= succ(q);
                            end
                        end
                    end
                    LOCKED: begin
                        prev <= q;
                        if (seq_match) begin
                            expected <= succ(q);
                        end else begin
                            // An error in the same cycle as err_clr leaves a fresh count of one.
                            err_pulse  <= 1'b1;
                            err_sticky <= 1'b1;
                            err_count  <= err_clr ? ERR_ONE : err_count_inc;
                            state      <= SEARCH;
                            expected   <= 4'd0;
                            run        <= q_in_range ? 4'd1 : 4'd0;
                            prev_ok    <= q_in_range;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef COUNT1TO10_MON_LAP_EN
    logic lap_hit;
    assign lap_hit = q_valid && (state == LOCKED) && seq_match &&
                     (prev == 4'd10) && (q == 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_count <= '0;
        end else if (lap_hit) begin
            lap_count <= lap_count + LAP_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_count1to10_monitor.sv
// Directed bench for count1to10_monitor: default instance plus a LOCK_LEN=2 / ERR_W=2 instance for saturation.
module tb_count1to10_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] q1 = 4'd0, q2 = 4'd0;
    logic       v1 = 1'b0, v2 = 1'b0, c1 = 1'b0, c2 = 1'b0;

    logic       locked1, pulse1, sticky1;
    logic [3:0] exp1;
    logic [7:0] cnt1;
    logic       locked2, pulse2, sticky2;
    logic [3:0] exp2;
    logic [1:0] cnt2;
`ifdef COUNT1TO10_MON_LAP_EN
    logic [7:0] lap1, lap2;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic       lk;
        logic [3:0] ex;
        logic       pl;
        logic       st;
        logic [7:0] cnt;
        logic [7:0] lap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    count1to10_monitor u_dut1 (
        .clk(clk), .reset(reset), .q(q1), .q_valid(v1), .err_clr(c1),
        .locked(locked1), .expected(exp1), .err_pulse(pulse1),
        .err_sticky(sticky1), .err_count(cnt1)
`ifdef COUNT1TO10_MON_LAP_EN
        , .lap_count(lap1)
`endif
    );

    count1to10_monitor #(.LOCK_LEN(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .q(q2), .q_valid(v2), .err_clr(c2),
        .locked(locked2), .expected(exp2), .err_pulse(pulse2),
        .err_sticky(sticky2), .err_count(cnt2)
`ifdef COUNT1TO10_MON_LAP_EN
        , .lap_count(lap2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic step(input logic [3:0] qi, input logic vi, input logic ci,
                        input logic lk, input logic [3:0] ex, input logic pl,
                        input logic st, input logic [7:0] cnt, input logic [7:0] lap);
        exp_t e;
        q1 = qi; v1 = vi; c1 = ci;
        sb.push_back('{lk, ex, pl, st, cnt, lap});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("locked q=%0d", qi), locked1, e.lk);
        chk($sformatf("expected q=%0d", qi), exp1, e.ex);
        chk($sformatf("err_pulse q=%0d", qi), pulse1, e.pl);
        chk($sformatf("err_sticky q=%0d", qi), sticky1, e.st);
        chk($sformatf("err_count q=%0d", qi), cnt1, e.cnt);
`ifdef COUNT1TO10_MON_LAP_EN
        chk($sformatf("lap_count q=%0d", qi), lap1, e.lap);
`endif
        v1 = 1'b0; c1 = 1'b0;
    endtask

    task automatic step2(input logic [3:0] qi, input logic lk, input logic [1:0] cnt);
        q2 = qi; v2 = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("sat locked q=%0d", qi), locked2, lk);
        chk($sformatf("sat err_count q=%0d", qi), cnt2, cnt);
        v2 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset locked", locked1, 1'b0);
        chk("reset expected", exp1, 4'd0);
        chk("reset err_pulse", pulse1, 1'b0);
        chk("reset err_sticky", sticky1, 1'b0);
        chk("reset err_count", cnt1, 8'd0);
        reset = 1'b0;

        // lock on 1,2,3
        step(4'd1,  1, 0, 0, 4'd0,  0, 0, 8'd0, 8'd0);
        step(4'd2,  1, 0, 0, 4'd0,  0, 0, 8'd0, 8'd0);
        step(4'd3,  1, 0, 1, 4'd4,  0, 0, 8'd0, 8'd0);
        // run through a wrap
        for (int i = 4; i <= 10; i++)
            step(4'(i), 1, 0, 1, (i == 10) ? 4'd1 : 4'(i + 1), 0, 0, 8'd0, 8'd0);
        step(4'd1,  1, 0, 1, 4'd2,  0, 0, 8'd0, 8'd1);
        step(4'd2,  1, 0, 1, 4'd3,  0, 0, 8'd0, 8'd1);
        step(4'd3,  1, 0, 1, 4'd4,  0, 0, 8'd0, 8'd1);
        step(4'd4,  1, 0, 1, 4'd5,  0, 0, 8'd0, 8'd1);
        // break with expected=5, pulse lasts one cycle, then relock
        step(4'd7,  1, 0, 0, 4'd0,  1, 1, 8'd1, 8'd1);
        step(4'd0,  0, 0, 0, 4'd0,  0, 1, 8'd1, 8'd1);
        step(4'd8,  1, 0, 0, 4'd0,  0, 1, 8'd1, 8'd1);
        step(4'd9,  1, 0, 1, 4'd10, 0, 1, 8'd1, 8'd1);
        step(4'd10, 1, 0, 1, 4'd1,  0, 1, 8'd1, 8'd1);
        // second error, then out-of-range samples with idle gaps
        step(4'd5,  1, 0, 0, 4'd0,  1, 1, 8'd2, 8'd1);
        step(4'd1,  1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd2,  1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd3,  0, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd0,  1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd4,  0, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd11, 1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd3,  1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd9,  0, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd4,  1, 0, 0, 4'd0,  0, 1, 8'd2, 8'd1);
        step(4'd5,  1, 0, 1, 4'd6,  0, 1, 8'd2, 8'd1);
        // error and clear together, then clear alone
        step(4'd9,  1, 1, 0, 4'd0,  1, 1, 8'd1, 8'd1);
        step(4'd0,  0, 1, 0, 4'd0,  0, 0, 8'd0, 8'd1);
        // 10 -> 1 while searching is not a lap
        step(4'd10, 1, 0, 0, 4'd0,  0, 0, 8'd0, 8'd1);
        step(4'd1,  1, 0, 1, 4'd2,  0, 0, 8'd0, 8'd1);
        step(4'd5,  1, 0, 0, 4'd0,  1, 1, 8'd1, 8'd1);
        step(4'd6,  1, 0, 0, 4'd0,  0, 1, 8'd1, 8'd1);
        step(4'd7,  1, 0, 1, 4'd8,  0, 1, 8'd1, 8'd1);

        // saturation on the 2-bit error counter, LOCK_LEN=2
        step2(4'd1, 0, 2'd0);
        step2(4'd2, 1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step2(4'd5, 0, (i >= 2) ? 2'd3 : 2'(i + 1));
            step2(4'd6, 1, (i >= 2) ? 2'd3 : 2'(i + 1));
        end
        chk("sat expected", exp2, 4'd7);

        // asynchronous reset between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async locked", locked1, 1'b0);
        chk("async expected", exp1, 4'd0);
        chk("async err_sticky", sticky1, 1'b0);
        chk("async err_count", cnt1, 8'd0);
        chk("async sat err_count", cnt2, 2'd0);
        chk("async sat locked", locked2, 1'b0);
`ifdef COUNT1TO10_MON_LAP_EN
        chk("async lap_count", lap1, 8'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        step(4'd1,  1, 0, 0, 4'd0,  0, 0, 8'd0, 8'd0);
        step(4'd2,  1, 0, 0, 4'd0,  0, 0, 8'd0, 8'd0);
        step(4'd3,  1, 0, 1, 4'd4,  0, 0, 8'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/count1to10_monitor.md
# count1to10_monitor

Sequence checker for the 4-bit decade counter that counts 1..10 and wraps to 1. It sits on the receiving end of a counter's `q` bus and samples the bus on qualified cycles. It locks onto the 1..10 sequence and then flags every sample that breaks the sequence. It also keeps error and completed-lap statistics, so a bench or on-chip monitor can confirm the counter's behaviour without a reference model.

## Interface
Parameters:
- `LOCK_LEN`, default 3: number of consecutive in-sequence valid samples needed to declare lock. Legal range is 2..15.
- `ERR_W`, default 8: width of the error counter.
- `LAP_W`, default 8: width of the lap counter. Used only with `COUNT1TO10_MON_LAP_EN`.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `q`  in  4  counter value under observation.
- `q_valid`  in  1  sample `q` this cycle; when low, all state holds.
- `err_clr`  in  1  synchronous clear of `err_sticky` and `err_count`.
- `locked`  out  1  high while the monitor is locked to the sequence.
- `expected`  out  4  next value expected while locked; 0 while unlocked.
- `err_pulse`  out  1  one-cycle strobe per detected sequence break.
- `err_sticky`  out  1  set on any break; held until `err_clr` or `reset`.
- `err_count`  out  `ERR_W`  number of breaks, saturating at all-ones.
- `lap_count`  out  `LAP_W`  number of observed 10→1 wraps while locked. Present only with the macro.

## Operation
- succ(x) is 1 when x = 10, otherwise x+1. In-range means q is in 1..10.
- Internal state:
  - `prev`, 4 bits.
  - `prev_ok`, 1 bit: `prev` holds an in-range sample.
  - `run`, 4 bits: consecutive in-sequence samples.
  - FSM with states SEARCH and LOCKED.
- SEARCH, on each valid sample:
  - q out of range: `run`=0, `prev_ok`=0.
  - q in range and `prev_ok` and q = succ(`prev`): `run`=`run`+1.
  - Any other in-range q: `run`=1.
  - In both in-range cases, `prev`=q and `prev_ok`=1.
  - When the updated `run` equals `LOCK_LEN`, go to LOCKED and set `expected` = succ(q).
  - No errors are reported in SEARCH.
- LOCKED, on each valid sample:
  - q = `expected`: stay LOCKED and set `expected` = succ(q). If `prev` = 10 and q = 1, increment `lap_count` (wraps modulo 2^`LAP_W`).
  - q ≠ `expected`:
    - Assert `err_pulse`, set `err_sticky`, and increment `err_count` (saturating).
    - Go to SEARCH with `expected`=0.
    - If q is in range: `run`=1, `prev`=q, `prev_ok`=1. Otherwise: `run`=0, `prev_ok`=0.
  - `prev`=q on every valid sample.
- `err_clr` zeroes `err_sticky` and `err_count`. If a new error occurs in the same cycle, the error wins: `err_sticky`=1 and `err_count`=1.
- `lap_count` is not affected by `err_clr`.
- Reset values: `locked`=0, `expected`=0, `err_pulse`=0, `err_sticky`=0, `err_count`=0, `lap_count`=0. Internal state resets to SEARCH with `run`=0, `prev`=0, `prev_ok`=0.

## Timing
- All outputs are registered. Every response appears on the rising edge that samples the `q_valid` cycle, so it is visible one cycle later.
- `locked` rises on the edge that captures the `LOCK_LEN`-th in-sequence sample. It falls on the edge that captures the first mismatch, which is the same edge on which `err_pulse` rises.
- `err_pulse` is high for exactly one cycle per error. Back-to-back errors are impossible, because the monitor is in SEARCH after any error.
- `q_valid` low holds all state. `err_pulse` still drops to 0, and `err_clr` still acts.
- Reset asserted mid-operation forces all outputs to reset values immediately, independent of `clk`. Release takes effect on the next edge.

## Configuration
- `COUNT1TO10_MON_LAP_EN` defined: the `lap_count` port and its counter exist.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Lock: after reset, valid q = 1,2,3 → `locked`=1 after the third sample with `expected`=4. `err_count` stays 0.
- Wrap and lap: locked, feed 8,9,10,1,2 → no error, `lap_count` increments by 1 on the 1. `expected`=3.
- Break: locked with `expected`=5, feed 7 → `err_pulse` for one cycle, `locked`=0, `err_sticky`=1, `err_count`=1. Then 8,9,10 → relock with `expected`=1.
- Out of range: in SEARCH, feed 1,2,0,11,3,4,5 → no lock until the 5; `err_count` unchanged. With `q_valid` low between samples, the result is the same.
- Clear vs error: locked with `expected`=6, drive q=9 with `err_clr`=1 → `err_sticky`=1, `err_count`=1. Next cycle, `err_clr` alone → both 0.
- Async reset and saturation: force `ERR_W`=2 and cause 5 errors → `err_count`=3. Assert `reset` between clock edges → all outputs 0 before the next edge.
